// File: rtl/axi_stream_rx_packer.sv
// AXI-Stream width upsizer for the Ethernet RX path: packs narrow beats little-endian
// into wide beats, fixes up tkeep on short final beats and keeps frame/error counters.

package axi_stream_rx_packer_pkg;

  typedef struct packed {
    logic       tvalid;
    logic [7:0] tdata;
    logic [0:0] tkeep;
    logic       tlast;
    logic [0:0] tid;
    logic [0:0] tdest;
    logic [0:0] tuser;
  } in_req_t;

  typedef struct packed {
    logic tready;
  } in_rsp_t;

  typedef struct packed {
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic [0:0]  tid;
    logic [0:0]  tdest;
    logic [0:0]  tuser;
  } out_req_t;

  typedef struct packed {
    logic tready;
  } out_rsp_t;

endpackage

module axi_stream_rx_packer #(
  parameter int unsigned DataWidthIn  = 8,
  parameter int unsigned DataWidthOut = 64,
  parameter int unsigned IdWidth      = 0,
  parameter int unsigned DestWidth    = 0,
  parameter int unsigned UserWidth    = 1,
  parameter int unsigned CntWidth     = 32,
  parameter type axi_stream_in_req_t  = axi_stream_rx_packer_pkg::in_req_t,
  parameter type axi_stream_in_rsp_t  = axi_stream_rx_packer_pkg::in_rsp_t,
  parameter type axi_stream_out_req_t = axi_stream_rx_packer_pkg::out_req_t,
  parameter type axi_stream_out_rsp_t = axi_stream_rx_packer_pkg::out_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_stream_in_req_t  in_req_i,
  output axi_stream_in_rsp_t  in_rsp_o,
  output axi_stream_out_req_t out_req_o,
  input  axi_stream_out_rsp_t out_rsp_i,
  input  logic                cnt_clear_i,
  output logic [CntWidth-1:0] frame_cnt_o,
  output logic [CntWidth-1:0] err_cnt_o
);

  localparam int unsigned R        = DataWidthOut / DataWidthIn;
  localparam int unsigned KeepIn   = DataWidthIn / 8;
  localparam int unsigned KeepOut  = DataWidthOut / 8;
  localparam int unsigned LaneW    = $clog2(R);
  // Zero-width id/dest fields are carried as a single unused bit.
  localparam int unsigned IdW      = (IdWidth > 0) ? IdWidth : 1;
  localparam int unsigned DestW    = (DestWidth > 0) ? DestWidth : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(R - 1);

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [LaneW-1:0]        r_lane_p0;
  logic [DataWidthOut-1:0] r_acc_data_p0;
  logic [KeepOut-1:0]      r_acc_keep_p0;
  logic [UserWidth-1:0]    r_acc_user_p0;
  logic                    r_sticky_err_p0;
  logic [IdW-1:0]          r_tid_p0;
  logic [DestW-1:0]        r_tdest_p0;

  logic                    r_vld_p1;
  logic [DataWidthOut-1:0] r_data_p1;
  logic [KeepOut-1:0]      r_keep_p1;
  logic                    r_last_p1;
  logic [UserWidth-1:0]    r_user_p1;
  logic [IdW-1:0]          r_tid_p1;
  logic [DestW-1:0]        r_tdest_p1;

  logic [CntWidth-1:0]     r_frame_cnt;
  logic [CntWidth-1:0]     r_err_cnt;

  logic                    w_in_ready;
  logic                    w_in_hs;
  logic                    w_complete;
  logic                    w_out_hs;
  logic [DataWidthOut-1:0] w_beat_data;
  logic [KeepOut-1:0]      w_beat_keep;
  logic [UserWidth-1:0]    w_beat_user;
  logic [IdW-1:0]          w_beat_tid;
  logic [DestW-1:0]        w_beat_tdest;

  assign w_in_ready = !r_vld_p1 || out_rsp_i.tready;
  assign w_in_hs    = in_req_i.tvalid && w_in_ready;
  assign w_complete = w_in_hs && (in_req_i.tlast || (r_lane_p0 == LastLane));
  assign w_out_hs   = r_vld_p1 && out_rsp_i.tready;

  // Lanes above k are always zero in the accumulator, so the merged beat
  // already has tdata/tkeep cleared in any unfilled lane.
  always_comb begin
    w_beat_data = r_acc_data_p0;
    w_beat_keep = r_acc_keep_p0;
    w_beat_data[32'(r_lane_p0) * DataWidthIn +: DataWidthIn] = in_req_i.tdata;
    w_beat_keep[32'(r_lane_p0) * KeepIn +: KeepIn]           = in_req_i.tkeep;
    w_beat_user = r_acc_user_p0 | in_req_i.tuser;
    if (in_req_i.tlast) begin
      w_beat_user[0] = r_sticky_err_p0 | in_req_i.tuser[0];
    end
    w_beat_tid   = (r_lane_p0 == '0) ? in_req_i.tid   : r_tid_p0;
    w_beat_tdest = (r_lane_p0 == '0) ? in_req_i.tdest : r_tdest_p0;
  end

  // Stage p0: lane accumulator
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lane_p0       <= '0;
      r_acc_data_p0   <= '0;
      r_acc_keep_p0   <= '0;
      r_acc_user_p0   <= '0;
      r_sticky_err_p0 <= 1'b0;
      r_tid_p0        <= '0;
      r_tdest_p0      <= '0;
    end else if (w_in_hs) begin
      if (r_lane_p0 == '0) begin
        r_tid_p0   <= in_req_i.tid;
        r_tdest_p0 <= in_req_i.tdest;
      end
      if (w_complete) begin
        r_lane_p0     <= '0;
        r_acc_data_p0 <= '0;
        r_acc_keep_p0 <= '0;
        r_acc_user_p0 <= '0;
      end else begin
        r_lane_p0     <= r_lane_p0 + 1'b1;
        r_acc_data_p0 <= w_beat_data;
        r_acc_keep_p0 <= w_beat_keep;
        r_acc_user_p0 <= w_beat_user;
      end
      if (in_req_i.tlast) begin
        r_sticky_err_p0 <= 1'b0;
      end else begin
        r_sticky_err_p0 <= r_sticky_err_p0 | in_req_i.tuser[0];
      end
    end
  end

  // Stage p1: single-entry output register, reloadable in the cycle it drains
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld_p1   <= 1'b0;
      r_data_p1  <= '0;
      r_keep_p1  <= '0;
      r_last_p1  <= 1'b0;
      r_user_p1  <= '0;
      r_tid_p1   <= '0;
      r_tdest_p1 <= '0;
    end else if (w_complete) begin
      r_vld_p1   <= 1'b1;
      r_data_p1  <= w_beat_data;
      r_keep_p1  <= w_beat_keep;
      r_last_p1  <= in_req_i.tlast;
      r_user_p1  <= w_beat_user;
      r_tid_p1   <= w_beat_tid;
      r_tdest_p1 <= w_beat_tdest;
    end else if (w_out_hs) begin
      r_vld_p1   <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (cnt_clear_i) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_out_hs && r_last_p1) begin
      r_frame_cnt <= sat_inc(r_frame_cnt);
      if (r_user_p1[0]) begin
        r_err_cnt <= sat_inc(r_err_cnt);
      end
    end
  end

  always_comb begin
    out_req_o        = '0;
    out_req_o.tvalid = r_vld_p1;
    out_req_o.tdata  = r_data_p1;
    out_req_o.tkeep  = r_keep_p1;
    out_req_o.tlast  = r_last_p1;
    out_req_o.tuser  = r_user_p1;
    out_req_o.tid    = r_tid_p1;
    out_req_o.tdest  = r_tdest_p1;
    in_rsp_o         = '0;
    in_rsp_o.tready  = w_in_ready;
  end

  assign frame_cnt_o = r_frame_cnt;
  assign err_cnt_o   = r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_ni && w_in_hs && !in_req_i.tlast) begin
      assert (&in_req_i.tkeep)
        else $error("axi_stream_rx_packer: partial tkeep on a non-last input beat");
    end
  end

endmodule

// File: tb/tb_axi_stream_rx_packer.sv
// Bench for axi_stream_rx_packer (8->64): directed and random frames checked
// against a byte-level frame model and a beat scoreboard.

module tb_axi_stream_rx_packer;
  import axi_stream_rx_packer_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } exp_beat_t;

  logic        clk;
  logic        rst_n;
  in_req_t     in_req;
  in_rsp_t     in_rsp, in_rsp4;
  out_req_t    out_req, out_req4;
  out_rsp_t    out_rsp;
  logic        cnt_clear;
  logic [31:0] frame_cnt, err_cnt;
  logic [3:0]  frame_cnt4, err_cnt4;

  exp_beat_t   exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_frames = 0;
  int          exp_errs = 0;
  int          rdy_low = 0;
  bit          rdy_hold = 0;
  bit          rdy_rand = 0;
  bit          gap_en = 0;
  bit          saw_stall = 0;

  axi_stream_rx_packer u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_req_i(in_req), .in_rsp_o(in_rsp),
    .out_req_o(out_req), .out_rsp_i(out_rsp), .cnt_clear_i(cnt_clear),
    .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt)
  );

  axi_stream_rx_packer #(.CntWidth(4)) u_dut_c4 (
    .clk_i(clk), .rst_ni(rst_n), .in_req_i(in_req), .in_rsp_o(in_rsp4),
    .out_req_o(out_req4), .out_rsp_i(out_rsp), .cnt_clear_i(cnt_clear),
    .frame_cnt_o(frame_cnt4), .err_cnt_o(err_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check_cnt(input string tag);
    check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
    check({tag, "_err_cnt"}, err_cnt, exp_errs);
    check({tag, "_frame_cnt4"}, frame_cnt4, sat15(exp_frames));
    check({tag, "_err_cnt4"}, err_cnt4, sat15(exp_errs));
  endtask

  // Frame model: bytes are chopped into 8-byte groups, little-endian; the last
  // group's error flag is the OR over the whole frame.
  function automatic void model_frame(input logic [7:0] b[$], input logic u[$]);
    int   n = b.size();
    int   nb = (n + 7) / 8;
    logic ferr = 1'b0;
    foreach (u[i]) ferr |= u[i];
    for (int j = 0; j < nb; j++) begin
      exp_beat_t e;
      e = '0;
      for (int i = 0; i < 8 && (j * 8 + i) < n; i++) begin
        e.data[i*8 +: 8] = b[j*8+i];
        e.keep[i]        = 1'b1;
        e.user          |= u[j*8+i];
      end
      e.last = (j == nb - 1);
      if (e.last) e.user = ferr;
      exp_q.push_back(e);
    end
    exp_frames++;
    if (ferr) exp_errs++;
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    int waited = 0;
    if (gap_en) begin
      while ($urandom_range(0, 3) == 0) begin
        in_req.tvalid = 1'b0;
        @(negedge clk);
      end
    end
    in_req.tvalid = 1'b1;
    in_req.tdata  = d;
    in_req.tkeep  = 1'b1;
    in_req.tlast  = l;
    in_req.tuser  = u;
    #1;
    while (in_rsp.tready !== 1'b1) begin
      saw_stall = 1'b1;
      waited++;
      if (waited > 2000) begin
        n_tests++;
        n_fail++;
        $display("FAIL input_ready_timeout: tready low for %0d cycles, required a handshake", waited);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "input handshake never completed");
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    in_req.tvalid = 1'b0;
  endtask

  task automatic run_frame(input int len, input int err_idx, input int base);
    logic [7:0] b[$];
    logic       u[$];
    for (int i = 0; i < len; i++) begin
      b.push_back((base < 0) ? 8'($urandom) : 8'(base + i));
      u.push_back(i == err_idx);
    end
    model_frame(b, u);
    for (int i = 0; i < len; i++) send_beat(b[i], i == len - 1, u[i]);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_req.tvalid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    assert (t < 5000) else begin
      n_fail++;
      $error("FAIL drain_timeout: %0d beats pending after %0d cycles, required 0", exp_q.size(), t);
    end
    @(negedge clk);
  endtask

  initial begin
    out_rsp = '0;
    forever begin
      @(negedge clk);
      if (rdy_low > 0) begin
        out_rsp.tready = 1'b0;
        rdy_low--;
      end else if (rdy_hold) out_rsp.tready = 1'b0;
      else if (rdy_rand)     out_rsp.tready = ($urandom_range(0, 3) != 0);
      else                   out_rsp.tready = 1'b1;
    end
  end

  // Scoreboard: beats are taken when valid&ready is seen between edges.
  initial begin
    exp_beat_t   e;
    bit          held = 1'b0;
    logic [63:0] held_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) held = 1'b0;
      else begin
        if (held) begin
          check("hold_valid", out_req.tvalid, 1'b1);
          check("hold_data", out_req.tdata, held_data);
        end
        if (out_req.tvalid && out_rsp.tready) begin
          n_tests++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_beat: observed beat 0x%0h, required none", out_req.tdata);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_tdata", out_req.tdata, e.data);
            check("beat_tkeep", out_req.tkeep, e.keep);
            check("beat_tlast", out_req.tlast, e.last);
            check("beat_tuser", out_req.tuser, e.user);
          end
        end
        held      = out_req.tvalid && !out_rsp.tready;
        held_data = out_req.tdata;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_req    = '0;
    cnt_clear = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_req.tvalid, 1'b0);
    check("rst_out_tdata", out_req.tdata, 64'h0);
    check("rst_out_tkeep", out_req.tkeep, 8'h0);
    check("rst_out_tlast", out_req.tlast, 1'b0);
    check("rst_out_tuser", out_req.tuser, 1'b0);
    check("rst_in_ready", in_rsp.tready, 1'b1);
    check_cnt("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(16, -1, 0);
    drain();
    check_cnt("f16");
    run_frame(11, -1, 0);
    run_frame(1, -1, 'hAB);
    run_frame(20, 3, 'h20);
    run_frame(8, -1, 'h40);
    drain();
    check_cnt("directed");

    saw_stall = 1'b0;
    rdy_low   = 13;
    run_frame(24, -1, -1);
    drain();
    check("bp_in_ready_dropped", saw_stall, 1'b1);
    check_cnt("bp");

    gap_en   = 1'b1;
    rdy_rand = 1'b1;
    for (int f = 0; f < 150; f++) begin
      int len;
      int err;
      len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(41, 1518)) : int'($urandom_range(1, 40));
      err = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_frame(len, err, -1);
      if (f == 19) begin
        drain();
        check_cnt("rand20");
      end
    end
    gap_en   = 1'b0;
    rdy_rand = 1'b0;
    drain();
    check_cnt("rand_all");

    rdy_hold = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(1, -1, 'h5A);
    repeat (2) @(negedge clk);
    #1;
    check("clr_pending_valid", out_req.tvalid, 1'b1);
    rdy_hold = 1'b0;
    @(negedge clk);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear  = 1'b0;
    exp_frames = 0;
    exp_errs   = 0;
    #1;
    check_cnt("clear");
    check("clr_out_drained", out_req.tvalid, 1'b0);
    @(negedge clk);

    run_frame(8, -1, 'h60);
    drain();
    check_cnt("pre_rst");
    for (int i = 0; i < 3; i++) send_beat(8'(8'hC0 + i), 1'b0, 1'b0);
    #1;
    rst_n      = 1'b0;
    exp_frames = 0;
    exp_errs   = 0;
    #3;
    check("rst_mid_valid", out_req.tvalid, 1'b0);
    check_cnt("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8, -1, 'h80);
    drain();
    check_cnt("post_rst");

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
